// File: rtl/hdlc_rx_deframer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdlc_rx_deframer: HDLC Rx flag/abort detection, zero destuffing, bytes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic [7:0] Rx_ByteCount
);

  // Window holds the newest bit in [0]; patterns read oldest-first from [7].
  localparam logic [7:0] c_FLAG  = 8'h7E;
  localparam logic [7:0] c_ABORT = 8'h7F;
  localparam logic [7:0] c_MAX   = 8'(MAX_BYTES);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_window;
  logic [7:0] r_valid;
  logic [2:0] r_ones;
  logic [2:0] r_bitCnt;
  logic       r_anyBits;
  logic [6:0] r_shift;

  logic       w_flag;
  logic       w_abort;
  logic       w_outBit;
  logic       w_outValid;
  logic       w_drop;
  logic       w_keep;
  logic [7:0] w_nextShift;

  assign w_flag      = (r_window == c_FLAG);
  assign w_abort     = (r_window == c_ABORT);
  assign w_outBit    = r_window[7];
  // The oldest bit of a just-detected flag leaves on the detect edge; suppress it with the rest.
  assign w_outValid  = r_valid[7] && !w_flag && !w_abort;
  assign w_drop      = w_outValid && !w_outBit && (r_ones == 3'd5);
  assign w_keep      = w_outValid && !w_drop;
  assign w_nextShift = {w_outBit, r_shift};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state        <= S_IDLE;
      r_window       <= 8'hFF;
      r_valid        <= 8'h00;
      r_ones         <= 3'd0;
      r_bitCnt       <= 3'd0;
      r_anyBits      <= 1'b0;
      r_shift        <= 7'd0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_Data        <= 8'd0;
      Rx_NewByte     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_ByteCount   <= 8'd0;
    end else begin
      r_window       <= {r_window[6:0], Rx};
      r_valid        <= w_flag ? 8'h01 : {r_valid[6:0], 1'b1};
      Rx_FlagDetect  <= w_flag;
      Rx_AbortDetect <= w_abort;
      Rx_NewByte     <= 1'b0;
      Rx_EoF         <= 1'b0;

      if (w_flag) begin
        r_ones <= 3'd0;
      end else if (w_outValid) begin
        if (!w_outBit)
          r_ones <= 3'd0;
        else if (r_ones != 3'd7)
          r_ones <= r_ones + 3'd1;
      end

      if (r_state == S_IDLE) begin
        Rx_ValidFrame <= 1'b0;
        if (w_flag) begin
          r_state       <= S_FRAME;
          Rx_ValidFrame <= 1'b1;
          Rx_ByteCount  <= 8'd0;
          Rx_Overflow   <= 1'b0;
          Rx_FrameError <= 1'b0;
          r_bitCnt      <= 3'd0;
          r_anyBits     <= 1'b0;
        end
      end else begin
        Rx_ValidFrame <= 1'b1;
        if (w_abort) begin
          r_state   <= S_IDLE;
          r_bitCnt  <= 3'd0;
          r_anyBits <= 1'b0;
        end else if (w_flag) begin
          // A flag with no data since the previous one is fill, not a frame close.
          if (r_anyBits) begin
            Rx_EoF        <= 1'b1;
            Rx_FrameError <= (r_bitCnt != 3'd0);
            Rx_ValidFrame <= 1'b0;
          end
          r_bitCnt  <= 3'd0;
          r_anyBits <= 1'b0;
        end else if (w_keep) begin
          r_anyBits <= 1'b1;
          r_bitCnt  <= r_bitCnt + 3'd1;
          r_shift   <= w_nextShift[7:1];
          // Status of the previous frame is held until this frame's first data bit.
          if (!r_anyBits) begin
            Rx_ByteCount  <= 8'd0;
            Rx_Overflow   <= 1'b0;
            Rx_FrameError <= 1'b0;
          end
          if (r_bitCnt == 3'd7) begin
            if (Rx_ByteCount < c_MAX) begin
              Rx_Data      <= w_nextShift;
              Rx_NewByte   <= 1'b1;
              Rx_ByteCount <= Rx_ByteCount + 8'd1;
            end else begin
              Rx_Overflow <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
